reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised successor to the core's 2-read/1-write integer register file. It adds configurable width and depth, a hard-wired zero register, and same-cycle write-to-read bypass. It also carries a per-register pending-write scoreboard and a sequenced, one-entry-per-cycle software clear. It sits in the decode/writeback path of the pipelined core: decode reads operands and busy flags, issue allocates destinations, writeback writes results.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of two, ≥ 2)
- AW, $clog2(NREG), address width (derived)
- ZERO_R0, 1, when 1, register 0 always reads 0 and ignores writes and allocs
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data (combinational)
- busy1, busy2  out  1  pending-write flag for ra1/ra2 (combinational)
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- alloc_en  in  1  mark alloc_addr as pending
- alloc_addr  in  AW  destination being allocated
- clr_req  in  1  start sequenced clear
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse at end of clear

## Operation
- Storage: NREG×XLEN array `r`; NREG-bit pending vector `pend`.
- Read: rdN = r[raN]; if ZERO_R0 and raN==0, rdN = 0. If BYPASS and we && wa==raN && !(ZERO_R0 && wa==0) && state==IDLE, rdN = wd.
- busyN = pend[raN]. When BYPASS, busyN is also forced to 0 by a qualifying same-cycle write to raN. busyN is 0 for r0 when ZERO_R0.
- Write (IDLE only): at the edge, r[wa] <= wd and pend[wa] <= 0.
- Alloc (IDLE only): at the edge, pend[alloc_addr] <= 1.
- Alloc and write to the same address in the same cycle: pend ends at 1, because alloc wins (new producer). r[wa] is still written.
- FSM states IDLE and CLEAR, with an AW-bit index `idx`.
  - IDLE→CLEAR on clr_req; idx <= 0.
  - In CLEAR, each edge sets r[idx] <= 0 and pend[idx] <= 0, then idx <= idx+1.
  - At idx==NREG-1, go to CLEAR→IDLE; clr_done is 1 for the following cycle.
- During CLEAR:
  - we, alloc_en and clr_req are ignored and their requests dropped.
  - Reads return current array contents; entries below idx read 0.
  - Bypass is disabled.
- idx wraps only via the terminal transition. No partial clears.

## Timing
- Reset (rst_n low, asynchronous): all r = 0, pend = 0, state IDLE, idx = 0, clr_busy = 0, clr_done = 0. While reset is asserted, rd1 and rd2 read 0 and busy1 and busy2 read 0.
- Reset asserted mid-clear aborts the sequence immediately. No clr_done pulse is produced.
- Read latency is 0 cycles (combinational). Write visibility:
  - Without bypass, a write is visible one cycle after the write edge.
  - With bypass, it is visible in the same cycle.
- clr_req sampled at edge k:
  - clr_busy = 1 from after edge k through edge k+NREG.
  - Entry i is cleared at edge k+1+i.
  - clr_done = 1 for the single cycle after edge k+NREG; clr_busy = 0 in that cycle.
- A write accepted with IDLE at edge k wins over nothing. The earliest a new clr_req can be taken is the clr_done cycle.
- Multiple writes are impossible: there is one write port. Reads of r0 with ZERO_R0 return 0 even with bypass.

## Test plan
- Reset/zero: with rst_n low then high, read all 32 registers → every rd is 0 and busy is 0; write r0 = 0xDEADBEEF → r0 reads 0.
- Write/read and bypass: in one cycle set we=1, wa=5, wd=0x12345678, ra1=5 → rd1 = 0x12345678 in the same cycle. With BYPASS=0, rd1 = 0 that cycle and 0x12345678 the next.
- Scoreboard: alloc r7 → busy1(ra1=7) = 1 next cycle. Write r7 = 0xA5 → busy1 = 0 in that cycle (bypass) and after. Alloc and write r9 in the same cycle → busy for r9 stays 1.
- Clear sequence: fill r1..r31 with index values, pulse clr_req → clr_busy high for exactly 32 cycles, then one clr_done pulse, then all registers and pend are 0. A write to r3 issued mid-clear is dropped (r3 = 0 afterwards).
- Reset mid-clear: drop rst_n while idx = 10 → immediate IDLE, all zero, no clr_done pulse.
- Parametrisation: NREG=8, XLEN=16, ZERO_R0=0 → r0 is writable (0xBEEF read back), and the clear sequence lasts 8 cycles.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with optional hard-wired zero
// register, same-cycle write-to-read bypass, a per-register pending-write
// scoreboard and a sequenced one-entry-per-cycle clear.
module reg_file_sb #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int AW      = $clog2(NREG),
   parameter bit ZERO_R0 = 1'b1,
   parameter bit BYPASS  = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_addr,
   input  logic            clr_req,
   output logic            clr_busy,
   output logic            clr_done
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   r_q [NREG];
   logic [NREG-1:0]   pend_q;

   logic              wr_ok, alloc_ok, byp1, byp2;

   // r0 is a constant zero when ZERO_R0 is set: it never stores, never pends
   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return ZERO_R0 && (a == '0);
   endfunction

   // Requests are only honoured in IDLE; during a clear they are dropped
   assign wr_ok    = (state_q == IDLE) && we && !is_zero_reg(wa);
   assign alloc_ok = (state_q == IDLE) && alloc_en && !is_zero_reg(alloc_addr);

   // Bypass also requires reset deasserted so reads stay zero under reset
   assign byp1 = BYPASS && rst_n && wr_ok && (wa == ra1);
   assign byp2 = BYPASS && rst_n && wr_ok && (wa == ra2);

   assign clr_busy = (state_q == CLEAR);
   assign clr_done = done_q;

   // Read port 1: array/pend lookup, overridden by bypass, then by zero/reset
   always_comb begin
      rd1   = r_q[ra1];
      busy1 = pend_q[ra1];
      if (byp1) begin
         rd1   = wd;
         busy1 = 1'b0;
      end
      if (is_zero_reg(ra1) || !rst_n) begin
         rd1   = '0;
         busy1 = 1'b0;
      end
   end

   // Read port 2: same structure as port 1
   always_comb begin
      rd2   = r_q[ra2];
      busy2 = pend_q[ra2];
      if (byp2) begin
         rd2   = wd;
         busy2 = 1'b0;
      end
      if (is_zero_reg(ra2) || !rst_n) begin
         rd2   = '0;
         busy2 = 1'b0;
      end
   end

   // Clear sequencer next state: walk idx 0..NREG-1, pulse done after the last
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset aborts any clear without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Storage and scoreboard; alloc is applied after write so a new producer wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_q[i] <= '0;
         pend_q <= '0;
      end else if (state_q == CLEAR) begin
         r_q[idx_q]    <= '0;
         pend_q[idx_q] <= 1'b0;
      end else begin
         if (wr_ok) begin
            r_q[wa]    <= wd;
            pend_q[wa] <= 1'b0;
         end
         if (alloc_ok) pend_q[alloc_addr] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb covering reset, zero
// register, bypass (on and off), scoreboard, sequenced clear, reset during
// clear, and a small NREG=8 / XLEN=16 / ZERO_R0=0 configuration.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  ra1, ra2, wa, alloc_addr;
   logic [31:0] wd;
   logic        we, alloc_en, clr_req;

   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
   logic        busy1, busy2, clr_busy, clr_done;
   logic        nb_busy1, nb_busy2, nb_clr_busy, nb_clr_done;

   logic [2:0]  p_ra1, p_ra2, p_wa, p_alloc_addr;
   logic [15:0] p_wd, p_rd1, p_rd2;
   logic        p_we, p_alloc_en, p_clr_req;
   logic        p_busy1, p_busy2, p_clr_busy, p_clr_done;

   int ntests = 0;
   int nfail  = 0;
   int cnt;

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .clr_req(clr_req),
      .clr_busy(clr_busy), .clr_done(clr_done)
   );

   reg_file_sb #(.BYPASS(1'b0)) nb (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
      .busy1(nb_busy1), .busy2(nb_busy2), .we(we), .wa(wa), .wd(wd),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .clr_req(clr_req),
      .clr_busy(nb_clr_busy), .clr_done(nb_clr_done)
   );

   reg_file_sb #(.XLEN(16), .NREG(8), .ZERO_R0(1'b0)) p8 (
      .clk(clk), .rst_n(rst_n), .ra1(p_ra1), .ra2(p_ra2), .rd1(p_rd1), .rd2(p_rd2),
      .busy1(p_busy1), .busy2(p_busy2), .we(p_we), .wa(p_wa), .wd(p_wd),
      .alloc_en(p_alloc_en), .alloc_addr(p_alloc_addr), .clr_req(p_clr_req),
      .clr_busy(p_clr_busy), .clr_done(p_clr_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      ra1 = '0; ra2 = '0; wa = '0; wd = '0; alloc_addr = '0;
      we = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
      p_ra1 = '0; p_ra2 = '0; p_wa = '0; p_wd = '0; p_alloc_addr = '0;
      p_we = 1'b0; p_alloc_en = 1'b0; p_clr_req = 1'b0;

      // Reset: outputs zero even with a would-be bypass on the port
      we = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF; ra1 = 5'd5;
      #12;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_busy1", {31'b0, busy1}, 32'h0);
      chk("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
      chk("rst_clr_done", {31'b0, clr_done}, 32'h0);
      we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // All registers read zero and not busy after reset
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i);
         #1;
         chk($sformatf("post_rst_rd1_r%0d", i), rd1, 32'h0);
         chk($sformatf("post_rst_busy2_r%0d", 31 - i), {31'b0, busy2}, 32'h0);
      end

      // r0 ignores writes, including through the bypass
      we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra1 = 5'd0;
      #1;
      chk("r0_bypass", rd1, 32'h0);
      step();
      we = 1'b0;
      #1;
      chk("r0_after", rd1, 32'h0);

      // Bypass on vs off
      we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra1 = 5'd5; ra2 = 5'd5;
      #1;
      chk("byp_same_cycle", rd1, 32'h1234_5678);
      chk("byp_same_cycle_p2", rd2, 32'h1234_5678);
      chk("nobyp_same_cycle", nb_rd1, 32'h0);
      step();
      we = 1'b0;
      #1;
      chk("byp_next", rd1, 32'h1234_5678);
      chk("nobyp_next", nb_rd1, 32'h1234_5678);

      // Scoreboard: alloc r7, then write it
      alloc_en = 1'b1; alloc_addr = 5'd7; ra1 = 5'd7;
      #1;
      chk("alloc_not_yet", {31'b0, busy1}, 32'h0);
      step();
      alloc_en = 1'b0;
      #1;
      chk("alloc_busy", {31'b0, busy1}, 32'h1);
      we = 1'b1; wa = 5'd7; wd = 32'h0000_00A5;
      #1;
      chk("wr_busy_byp", {31'b0, busy1}, 32'h0);
      chk("wr_rd_byp", rd1, 32'h0000_00A5);
      chk("wr_busy_nobyp", {31'b0, nb_busy1}, 32'h1);
      step();
      we = 1'b0;
      #1;
      chk("wr_busy_after", {31'b0, busy1}, 32'h0);
      chk("wr_busy_after_nb", {31'b0, nb_busy1}, 32'h0);

      // Alloc and write r9 together: pending stays set
      alloc_en = 1'b1; alloc_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99; ra2 = 5'd9;
      #1;
      chk("aw_busy_byp", {31'b0, busy2}, 32'h0);
      step();
      alloc_en = 1'b0; we = 1'b0;
      #1;
      chk("aw_busy_after", {31'b0, busy2}, 32'h1);
      chk("aw_rd_after", rd2, 32'h99);

      // Alloc of r0 is ignored
      alloc_en = 1'b1; alloc_addr = 5'd0; ra1 = 5'd0;
      step();
      alloc_en = 1'b0;
      #1;
      chk("r0_alloc", {31'b0, busy1}, 32'h0);

      // Fill r1..r31 with their index, then mark r12 pending
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; wa = 5'(i); wd = 32'(i);
         step();
      end
      we = 1'b0;
      alloc_en = 1'b1; alloc_addr = 5'd12;
      step();
      alloc_en = 1'b0;
      ra1 = 5'd17; ra2 = 5'd12;
      #1;
      chk("fill_r17", rd1, 32'd17);
      chk("fill_busy12", {31'b0, busy2}, 32'h1);

      // Sequenced clear with a dropped mid-clear write
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      cnt = 0;
      for (int j = 0; j < 40 && clr_busy; j++) begin
         cnt++;
         if (j == 2) begin
            we = 1'b1; wa = 5'd3; wd = 32'h333; ra1 = 5'd3; ra2 = 5'd1;
            #1;
            chk("clr_no_bypass", rd1, 32'd3);
            chk("clr_below_idx", rd2, 32'h0);
         end
         step();
         we = 1'b0;
      end
      chk("clr_busy_cycles", cnt, 32'd32);
      chk("clr_done_pulse", {31'b0, clr_done}, 32'h1);
      chk("clr_done_nb", {31'b0, nb_clr_done}, 32'h1);
      step();
      chk("clr_done_gone", {31'b0, clr_done}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(i);
         #1;
         chk($sformatf("clr_rd_r%0d", i), rd1, 32'h0);
         chk($sformatf("clr_busy_r%0d", i), {31'b0, busy2}, 32'h0);
      end
      chk("clr_nb_r3", nb_rd1, 32'h0);

      // Reset during a clear at idx 10
      we = 1'b1; wa = 5'd20; wd = 32'h2020;
      alloc_en = 1'b1; alloc_addr = 5'd21;
      step();
      we = 1'b0; alloc_en = 1'b0;
      ra1 = 5'd20; ra2 = 5'd21;
      #1;
      chk("pre_rst_r20", rd1, 32'h2020);
      chk("pre_rst_busy21", {31'b0, busy2}, 32'h1);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int j = 0; j < 10; j++) step();
      chk("mid_clr_r20", rd1, 32'h2020);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_clr_busy", {31'b0, clr_busy}, 32'h0);
      chk("rst_mid_r20", rd1, 32'h0);
      chk("rst_mid_busy21", {31'b0, busy2}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_r20_rel", rd1, 32'h0);
      cnt = 0;
      for (int j = 0; j < 40; j++) begin
         step();
         if (clr_done || clr_busy) cnt++;
      end
      chk("rst_mid_no_done", cnt, 32'h0);

      // NREG=8, XLEN=16, ZERO_R0=0 instance
      p_we = 1'b1; p_wa = 3'd0; p_wd = 16'hBEEF; p_ra1 = 3'd0;
      #1;
      chk("p8_r0_byp", {16'b0, p_rd1}, 32'h0000_BEEF);
      step();
      p_we = 1'b0;
      #1;
      chk("p8_r0_after", {16'b0, p_rd1}, 32'h0000_BEEF);
      p_clr_req = 1'b1;
      step();
      p_clr_req = 1'b0;
      cnt = 0;
      for (int j = 0; j < 20 && p_clr_busy; j++) begin
         cnt++;
         step();
      end
      chk("p8_clr_cycles", cnt, 32'd8);
      chk("p8_clr_done", {31'b0, p_clr_done}, 32'h1);
      #1;
      chk("p8_r0_cleared", {16'b0, p_rd1}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
